// File: rtl/dds_mc_pkg.sv
// rtl/dds_mc_pkg.sv - shared cfg_sel encodings, pipeline latency and sine table generator
package dds_mc_pkg;

    localparam logic CFG_SEL_FWORD = 1'b0;
    localparam logic CFG_SEL_PWORD = 1'b1;

    // Clocks from accumulator value to its sample on dout
    localparam int LAT = 2;

    localparam real PI = 3.14159265358979323846;

    // round(amp * sin(2*pi*addr/2^pword_w)), half away from zero so the table is odd-symmetric
    function automatic int sine_sample(input int addr, input int pword_w, input int data_w);
        real amp;
        real x;
        amp = real'((1 << (data_w - 1)) - 1);
        x   = amp * $sin(2.0 * PI * real'(addr) / real'(1 << pword_w));
        if (x >= 0.0) begin
            return int'($floor(x + 0.5));
        end
        return -int'($floor(-x + 0.5));
    endfunction

endpackage

// File: rtl/dds_mc_lut.sv
// rtl/dds_mc_lut.sv - registered sine lookup; quarter-wave table when DDS_MC_QUARTER_WAVE_EN is defined
module dds_mc_lut
    import dds_mc_pkg::*;
#(
    parameter int PWORD_W = 12,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PWORD_W-1:0] addr,
    output logic [DATA_W-1:0]  q
);

    logic signed [DATA_W-1:0] sample;

`ifdef DDS_MC_QUARTER_WAVE_EN
    localparam int QW    = PWORD_W - 2;
    localparam int DEPTH = 1 << QW;
    localparam logic signed [DATA_W-1:0] PEAK = DATA_W'((1 << (DATA_W - 1)) - 1);

    logic signed [DATA_W-1:0] rom [DEPTH];
    logic [1:0]               quad;
    logic [QW-1:0]            idx;
    logic [QW-1:0]            ridx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = DATA_W'(sine_sample(i, PWORD_W, DATA_W));
    end

    assign quad = addr[PWORD_W-1 -: 2];
    assign idx  = addr[QW-1:0];
    // Mirrored index (quarter - idx); idx == 0 would need the entry one past the table,
    // which is the exact peak, so it is special-cased instead of stored
    assign ridx = ~idx + QW'(1);

    // Rebuild the full period from the first quadrant by mirroring and negation
    always_comb begin
        sample = '0;
        case (quad)
            2'd0:    sample = rom[idx];
            2'd1:    sample = (idx == '0) ? PEAK : rom[ridx];
            2'd2:    sample = -rom[idx];
            default: sample = (idx == '0) ? -PEAK : -rom[ridx];
        endcase
    end
`else
    localparam int DEPTH = 1 << PWORD_W;

    logic signed [DATA_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = DATA_W'(sine_sample(i, PWORD_W, DATA_W));
    end

    assign sample = rom[addr];
`endif

    // Output register: loads only samples that will be flagged valid, otherwise holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= sample;
        end
    end

endmodule

// File: rtl/dds_mc.sv
// rtl/dds_mc.sv - multi-channel DDS with shadowed retune; DDS_MC_QUARTER_WAVE_EN selects quarter-wave LUTs
module dds_mc
    import dds_mc_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 32,
    parameter int PWORD_W = 12,
    parameter int DATA_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [3:0]               cfg_ch,
    input  logic                     cfg_sel,
    input  logic [PHASE_W-1:0]       cfg_data,
    input  logic                     update,
    input  logic                     sync_clr,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic                     dout_valid,
    output logic                     cfg_err
);

    localparam logic [4:0] NUM_CH_U = 5'(NUM_CH);

    logic [PHASE_W-1:0] shadow_fword [NUM_CH];
    logic [PHASE_W-1:0] active_fword [NUM_CH];
    logic [PHASE_W-1:0] acc          [NUM_CH];
    logic [PWORD_W-1:0] shadow_pword [NUM_CH];
    logic [PWORD_W-1:0] active_pword [NUM_CH];
    logic [PWORD_W-1:0] lut_addr     [NUM_CH];
    logic [LAT:0]       en_pipe;
    logic               cfg_fire;
    logic               cfg_ch_ok;
    logic               clear_acc;

    assign cfg_fire   = cfg_valid && cfg_ready;
    assign cfg_ch_ok  = {1'b0, cfg_ch} < NUM_CH_U;
    assign clear_acc  = update && sync_clr;
    assign dout_valid = en_pipe[LAT];

    // Not ready in the first cycle out of reset, ready ever after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
        end
    end

    // Sticky flag for accepted writes aimed at a channel that does not exist
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (cfg_fire && !cfg_ch_ok) begin
            cfg_err <= 1'b1;
        end
    end

    // Shadow registers take configuration writes; out-of-range writes are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                shadow_fword[ch] <= '0;
                shadow_pword[ch] <= '0;
            end
        end else if (cfg_fire && cfg_ch_ok) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (cfg_ch == 4'(ch)) begin
                    case (cfg_sel)
                        CFG_SEL_FWORD: shadow_fword[ch] <= cfg_data;
                        CFG_SEL_PWORD: shadow_pword[ch] <= cfg_data[PWORD_W-1:0];
                        default:       shadow_fword[ch] <= cfg_data;
                    endcase
                end
            end
        end
    end

    // All channels retune together; a same-cycle write is seen only by the shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                active_fword[ch] <= '0;
                active_pword[ch] <= '0;
            end
        end else if (update) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                active_fword[ch] <= shadow_fword[ch];
                active_pword[ch] <= shadow_pword[ch];
            end
        end
    end

    // Stage 1: phase accumulators; synchronous clear overrides en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc[ch] <= '0;
            end
        end else if (clear_acc) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc[ch] <= '0;
            end
        end else if (en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc[ch] <= acc[ch] + active_fword[ch];
            end
        end
    end

    // Stage 2: LUT address = accumulator MSBs plus phase offset, wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                lut_addr[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                lut_addr[ch] <= acc[ch][PHASE_W-1 -: PWORD_W] + active_pword[ch];
            end
        end
    end

    // en travels alongside the data so dout_valid marks stage-3 samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_pipe <= '0;
        end else begin
            en_pipe <= {en_pipe[LAT-1:0], en};
        end
    end

    // Stage 3: one registered sine lookup per channel, packed with channel 0 in the LSBs
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dds_mc_lut #(
            .PWORD_W (PWORD_W),
            .DATA_W  (DATA_W)
        ) u_lut (
            .clk  (clk),
            .rst  (rst),
            .load (en_pipe[LAT-1]),
            .addr (lut_addr[g]),
            .q    (dout[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_dds_mc.sv
// tb/tb_dds_mc.sv - directed and randomized self-checking bench for dds_mc
module tb_dds_mc;

    localparam int NUM_CH  = 4;
    localparam int PHASE_W = 32;
    localparam int PWORD_W = 12;
    localparam int DATA_W  = 8;
    localparam real TB_PI  = 3.14159265358979323846;

    logic                     clk       = 1'b0;
    logic                     rst       = 1'b1;
    logic                     en        = 1'b0;
    logic                     cfg_valid = 1'b0;
    logic                     cfg_ready;
    logic [3:0]               cfg_ch    = 4'd0;
    logic                     cfg_sel   = 1'b0;
    logic [PHASE_W-1:0]       cfg_data  = '0;
    logic                     update    = 1'b0;
    logic                     sync_clr  = 1'b0;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic                     dout_valid;
    logic                     cfg_err;

    dds_mc #(
        .NUM_CH  (NUM_CH),
        .PHASE_W (PHASE_W),
        .PWORD_W (PWORD_W),
        .DATA_W  (DATA_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_sel    (cfg_sel),
        .cfg_data   (cfg_data),
        .update     (update),
        .sync_clr   (sync_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_sine(input int a);
        real x;
        x = 127.0 * $sin(2.0 * TB_PI * real'(a) / 4096.0);
        if (x >= 0.0) return int'($floor(x + 0.5));
        return -int'($floor(-x + 0.5));
    endfunction

    function automatic int ch_val(input int ch);
        logic signed [7:0] s;
        s = dout[ch*DATA_W +: DATA_W];
        return int'(s);
    endfunction

    // Reference model: architectural state plus a record of the last two clock edges
    logic [31:0] m_sh_f [NUM_CH];
    logic [31:0] m_act_f[NUM_CH];
    logic [31:0] m_acc  [NUM_CH];
    logic [11:0] m_sh_p [NUM_CH];
    logic [11:0] m_act_p[NUM_CH];
    int          m_dout [NUM_CH];
    bit          m_valid, m_ready, m_err;
    bit          h_en   [2];
    logic [31:0] h_acc  [2][NUM_CH];
    logic [11:0] h_pw   [2][NUM_CH];

    task automatic m_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            m_sh_f[c] = 0; m_act_f[c] = 0; m_acc[c] = 0;
            m_sh_p[c] = 0; m_act_p[c] = 0; m_dout[c] = 0;
            for (int k = 0; k < 2; k++) begin
                h_acc[k][c] = 0; h_pw[k][c] = 0;
            end
        end
        h_en[0] = 0; h_en[1] = 0;
        m_valid = 0; m_ready = 0; m_err = 0;
    endtask

    task automatic m_step();
        int ci;
        // A sample is visible two edges after its accumulator value existed
        m_valid = h_en[1];
        if (h_en[1]) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_dout[c] = ref_sine(int'(((h_acc[1][c] >> 20) + 32'(h_pw[1][c])) & 32'hfff));
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (update && sync_clr) m_acc[c] = 0;
            else if (en)            m_acc[c] = m_acc[c] + m_act_f[c];
        end
        if (update) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_act_f[c] = m_sh_f[c];
                m_act_p[c] = m_sh_p[c];
            end
        end
        if (cfg_valid && m_ready) begin
            ci = int'(cfg_ch);
            if (ci >= NUM_CH) m_err = 1;
            else if (cfg_sel) m_sh_p[ci] = cfg_data[11:0];
            else              m_sh_f[ci] = cfg_data;
        end
        m_ready = 1;
        h_en[1] = h_en[0];
        h_en[0] = en;
        for (int c = 0; c < NUM_CH; c++) begin
            h_acc[1][c] = h_acc[0][c];
            h_pw[1][c]  = h_pw[0][c];
            h_acc[0][c] = m_acc[c];
            h_pw[0][c]  = m_act_p[c];
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_clear();
            else     m_step();
        end
    end

    bit collect = 0;
    int q0[$];
    int q1[$];

    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                check_eq($sformatf("dout_ch%0d", c), 64'(ch_val(c)), 64'(m_dout[c]));
            end
            check_eq("dout_valid", {63'd0, dout_valid}, {63'd0, m_valid});
            check_eq("cfg_ready",  {63'd0, cfg_ready},  {63'd0, m_ready});
            check_eq("cfg_err",    {63'd0, cfg_err},    {63'd0, m_err});
            if (collect && dout_valid) begin
                q0.push_back(ch_val(0));
                q1.push_back(ch_val(1));
            end
        end
    end

    task automatic drive(input bit e, input bit v, input int ch, input bit s,
                         input logic [31:0] d, input bit u, input bit c);
        @(negedge clk);
        #1;
        en = e; cfg_valid = v; cfg_ch = 4'(ch); cfg_sel = s;
        cfg_data = d; update = u; sync_clr = c;
    endtask

    task automatic idle(input int n, input bit e);
        repeat (n) drive(e, 0, 0, 0, 32'd0, 0, 0);
    endtask

    function automatic int period_of(input int q[$]);
        int first;
        first = -1;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i-1] < 0 && q[i] >= 0) begin
                if (first < 0) first = i;
                else return i - first;
            end
        end
        return -1;
    endfunction

    initial begin
        int mx, mn, bad, p0, p1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1 check_eq("ready_first_cycle", {63'd0, cfg_ready}, 64'd0);

        // Single tone on ch0, period 100
        drive(0, 1, 0, 0, 32'd42949672, 0, 0);
        q0.delete(); q1.delete(); collect = 1;
        drive(1, 0, 0, 0, 32'd0, 1, 1);
        idle(260, 1);
        collect = 0;
        check_eq("t1_first", 64'(q0[0]), 64'd0);
        mx = -1000; mn = 1000;
        foreach (q0[i]) begin
            if (q0[i] > mx) mx = q0[i];
            if (q0[i] < mn) mn = q0[i];
        end
        check_eq("t1_peak", 64'(mx), 64'd127);
        check_eq("t1_trough", 64'(mn), -64'sd127);
        check_eq("t1_period", 64'(period_of(q0)), 64'd100);

        // Phase offset of a quarter turn with zero frequency holds the peak
        idle(4, 0);
        drive(0, 1, 1, 1, 32'd1024, 0, 0);
        drive(0, 1, 1, 0, 32'd0, 0, 0);
        idle(3, 0);
        q0.delete(); q1.delete(); collect = 1;
        drive(1, 0, 0, 0, 32'd0, 1, 1);
        idle(20, 1);
        collect = 0;
        bad = 0;
        foreach (q1[i]) if (q1[i] != 127) bad++;
        check_eq("t2_ch1_const", 64'(bad), 64'd0);
        check_eq("t2_samples", 64'(q1.size()), 64'd18);

        // Two channels, 10:1 frequency ratio, coherent start
        idle(4, 0);
        drive(0, 1, 1, 1, 32'd0, 0, 0);
        drive(0, 1, 0, 0, 32'd429496729, 0, 0);
        drive(0, 1, 1, 0, 32'd42949672, 0, 0);
        idle(3, 0);
        q0.delete(); q1.delete(); collect = 1;
        drive(1, 0, 0, 0, 32'd0, 1, 1);
        idle(260, 1);
        collect = 0;
        check_eq("t3_first_ch0", 64'(q0[0]), 64'd0);
        check_eq("t3_first_ch1", 64'(q1[0]), 64'd0);
        p0 = period_of(q0);
        p1 = period_of(q1);
        check_eq("t3_period_ch0", 64'(p0), 64'd10);
        check_eq("t3_ratio", 64'(p1), 64'(10 * p0));

        // Out-of-range channel write
        drive(1, 1, 7, 0, 32'd123, 0, 0);
        idle(1, 1);
        check_eq("t4_err_set", {63'd0, cfg_err}, 64'd1);
        drive(1, 0, 0, 0, 32'd0, 1, 0);
        idle(10, 1);
        check_eq("t4_err_sticky", {63'd0, cfg_err}, 64'd1);

        // Write and update in the same cycle on ch2
        drive(1, 1, 2, 1, 32'd1024, 1, 0);
        idle(4, 1);
        check_eq("t5_old_active", 64'(ch_val(2)), 64'd0);
        drive(1, 0, 0, 0, 32'd0, 1, 0);
        idle(4, 1);
        check_eq("t5_new_active", 64'(ch_val(2)), 64'd127);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bit u, c, e, v, s;
            u = ($urandom_range(0, 7) == 0);
            c = u && ($urandom_range(0, 1) == 1);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 1) == 1);
            s = ($urandom_range(0, 1) == 1);
            drive(e, v, int'($urandom_range(0, 7)), s, 32'($urandom), u, c);
        end

        // Asynchronous reset mid-run
        drive(1, 1, 1, 1, 32'd1024, 0, 0);
        drive(1, 1, 1, 0, 32'd0, 0, 0);
        drive(1, 0, 0, 0, 32'd0, 1, 1);
        idle(5, 1);
        check_eq("t6_pre_ch1", 64'(ch_val(1)), 64'd127);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_dout_async", 64'(dout), 64'd0);
        check_eq("t6_valid_async", {63'd0, dout_valid}, 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0; en = 1'b0; update = 1'b0; sync_clr = 1'b0;
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_sel = 1'b0; cfg_data = 32'h4000_0000;
        #1 check_eq("t6_ready_low", {63'd0, cfg_ready}, 64'd0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        check_eq("t6_ready_high", {63'd0, cfg_ready}, 64'd1);
        drive(1, 0, 0, 0, 32'd0, 1, 1);
        idle(6, 1);
        check_eq("t6_lost_write", 64'(ch_val(0)), 64'd0);
        check_eq("t6_valid_back", {63'd0, dout_valid}, 64'd1);

        idle(3, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_mc.md
DDS_MC -- requirements
Module: dds_mc

Interface
- REQ-001: Parameter NUM_CH, default 4: number of independent DDS channels, 1..16.
- REQ-002: Parameter PHASE_W, default 32: phase accumulator and frequency word width.
- REQ-003: Parameter PWORD_W, default 12: phase word width and LUT address width.
- REQ-004: Parameter DATA_W, default 8: signed sample width per channel.
- REQ-005: clk  input  1  single clock; reset is asynchronous and active-high.
- REQ-006: rst  input  1  asynchronous, active-high reset.
- REQ-007: en  input  1  accumulator advance enable.
- REQ-008: cfg_valid  input  1  configuration write request.
- REQ-009: cfg_ready  output  1  configuration write accept.
- REQ-010: cfg_ch  input  4  target channel index.
- REQ-011: cfg_sel  input  1  write target: 0 = frequency word, 1 = phase word.
- REQ-012: cfg_data  input  PHASE_W  write data; the phase word uses the LSB PWORD_W bits.
- REQ-013: update  input  1  one-cycle strobe; copies all shadow words to the active words.
- REQ-014: sync_clr  input  1  qualified by update; also zeroes all accumulators.
- REQ-015: dout  output  NUM_CH*DATA_W  packed signed samples; channel 0 occupies the LSBs.
- REQ-016: dout_valid  output  1  dout qualifier.
- REQ-017: cfg_err  output  1  sticky flag: a write targeted a channel index ≥ NUM_CH.

Function
- REQ-018: A configuration write SHALL complete on a cycle where both cfg_valid and cfg_ready are high, and SHALL update only the shadow register selected by cfg_sel.
- REQ-019: cfg_ready SHALL be 1 in every cycle except the first cycle after reset deassertion.
- REQ-020: A write with cfg_ch ≥ NUM_CH SHALL be accepted, discarded, and SHALL set cfg_err.
- REQ-021: On an update strobe, all channels SHALL load their active fword and pword from their shadows in the same cycle (phase-coherent retune).
- REQ-022: When a write and an update occur in the same cycle, the update SHALL copy the pre-write shadow value; the write SHALL land in the shadow only.
- REQ-023: When update and sync_clr are both high, every accumulator SHALL become 0 on that edge, regardless of en.
- REQ-024: Otherwise, with en high, each accumulator SHALL take acc + active fword modulo 2^PHASE_W, wrapping silently.
- REQ-025: With en low, each accumulator SHALL hold its value.
- REQ-026: LUT address SHALL be acc[PHASE_W-1 -: PWORD_W] + pword, taken modulo 2^PWORD_W.
- REQ-027: LUT contents SHALL be round((2^(DATA_W-1)-1)·sin(2π·a/2^PWORD_W)), two's complement.
- REQ-028: The pipeline SHALL be: stage 1 accumulator, stage 2 address register, stage 3 output register. A sample SHALL appear on dout 2 clocks after its accumulator value (fixed latency LAT=2), in both builds.
- REQ-029: dout_valid SHALL equal en delayed by 3 clocks; when dout_valid is low, dout SHALL hold its value.

Reset
- REQ-030: Reset SHALL clear accumulators, shadow words, active words, pipeline registers, dout, dout_valid and cfg_err to 0, and SHALL drive cfg_ready to 0.
- REQ-031: Reset asserted mid-operation SHALL take effect immediately and asynchronously; a write in flight SHALL be lost.

Configuration
- REQ-032: With DDS_MC_QUARTER_WAVE_EN defined, the LUT SHALL store 2^(PWORD_W-2) entries and reconstruct the full wave by address mirroring and sign inversion; outputs SHALL be bit-identical to the full-table build.
- REQ-033: Without DDS_MC_QUARTER_WAVE_EN, the LUT SHALL store the full 2^PWORD_W-entry table.

Structure
- REQ-034: Package dds_mc_pkg SHALL hold the cfg_sel encodings, the LAT constant and the sine table generation function.
- REQ-035: Sub-module dds_mc_lut SHALL implement one registered sine lookup and SHALL be instantiated NUM_CH times.

Verification
- REQ-036: Defaults; write fword=42949672 to ch0; update+sync_clr; en=1 -> ch0 period is 100 clocks; first valid sample is 0; peak is +127 and trough is -127.
- REQ-037: Write pword=1024 to ch1 and fword=0; update+sync_clr -> ch1 holds constant +127 once dout_valid is high.
- REQ-038: ch0 fword=429496729, ch1 fword=42949672; update+sync_clr -> both channels show sample 0 on the same cycle; period ratio is 10:1.
- REQ-039: Write to cfg_ch=7 with NUM_CH=4 -> no channel changes and cfg_err=1 until reset.
- REQ-040: Write and update in the same cycle to ch2 -> the old value becomes active; the new value becomes active only on the next update.
- REQ-041: Assert rst mid-run for 1 clock -> dout=0 and dout_valid=0 immediately; cfg_ready=0 on the first post-reset cycle.
